register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port register file; next generation of the 32x32 2R/1W file.
//  Configurable width/depth, NUM_RD read ports, NUM_WR write ports, registered reads.
//  Write-first bypass, optional hardwired-zero entry 0, post-reset clear sequencer.
//  Sits in the CPU datapath between decode (addresses) and ALU/writeback.
// PARAMETERS
//  DATA_WIDTH  32  bits per entry
//  ADDR_WIDTH  5   address bits; DEPTH = 2**ADDR_WIDTH
//  NUM_RD      2   number of read ports (1..4)
//  NUM_WR      1   number of write ports (1..2)
//  ZERO_REG    1   1: entry 0 reads as 0; writes to it are dropped
// PORTS
//  CLK      in   1                    clock; all state updates on rising edge
//  RST      in   1                    reset, synchronous, active-high
//  RD_EN    in   NUM_RD               per-port read request
//  RD_ADDR  in   NUM_RD*ADDR_WIDTH    packed read addresses, port p at [p*AW +: AW]
//  RD_DATA  out  NUM_RD*DATA_WIDTH    packed registered read data
//  RD_VALID out  NUM_RD               1-cycle pulse: RD_DATA[p] updated this cycle
//  WR_EN    in   NUM_WR               per-port write request
//  WR_ADDR  in   NUM_WR*ADDR_WIDTH    packed write addresses
//  WR_DATA  in   NUM_WR*DATA_WIDTH    packed write data
//  BUSY     out  1                    1 while reset or clear sequence runs
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high. While RST=1 at an edge: RD_DATA=0,
//   RD_VALID=0, BUSY=1, clr_ptr=0, FSM->CLEAR. Array contents are not touched by RST.
//  FSM: CLEAR -> READY. In CLEAR, one entry per cycle: mem[clr_ptr]<=0,
//   clr_ptr++. After entry DEPTH-1 is written -> READY, BUSY=0 next edge.
//   A clear therefore takes DEPTH cycles after RST falls. RST in any state, including
//   mid-clear, restarts the clear from entry 0.
//  In CLEAR: RD_EN/WR_EN ignored, RD_VALID=0, RD_DATA holds value.
//  Writes (READY): mem[WR_ADDR[w]]<=WR_DATA[w] at the edge where WR_EN[w]=1.
//   Same address on several ports in one cycle: highest port index wins.
//   ZERO_REG=1 and addr 0: write dropped.
//  Reads (READY): latency 1. RD_EN[p]=1 at edge N -> RD_DATA[p], RD_VALID[p]=1
//   after edge N. RD_EN[p]=0 -> RD_VALID[p]=0, RD_DATA[p] holds.
//  Bypass (write-first): read addr equals an enabled write addr in the same cycle ->
//   RD_DATA gets the winning WR_DATA, never the stale entry.
//  ZERO_REG=1 and read addr 0 -> 0, with bypass suppressed.
//  Any number of ports may read the same address. There are no stalls; reads and
//   writes are accepted every READY cycle.
//  Widths: all address/data fields are exact; there is no sign or zero extension.
//   clr_ptr is ADDR_WIDTH+1 bits so completion is detected without wrap.
// STRUCTURE
//  Shared include/package rf_defs:
//   - FSM state encoding (RF_CLEAR=1'b0, RF_READY=1'b1)
//   - default width/depth constants, matching the global DATA/REG_ADDR definitions
//  Top: storage array, clear FSM, write-port priority resolution.
//  Sub-module rf_read_port:
//   - one per read port, via generate
//   - address mux, zero-reg check, write-first bypass compare, output register
// TESTING
//  1 RST=1 for 2 cycles, then 0 -> BUSY=1 for exactly 32 cycles. Every read after
//    BUSY falls returns 0. RD_VALID stays 0 during the clear even with RD_EN=1.
//  2 Write i*10 to addr i, i=0..31, then read R1=i, R2=i%7 -> R1=i*10, R2=(i%7)*10.
//    Addr 0 reads 0 (ZERO_REG=1). Each RD_VALID arrives 1 cycle after RD_EN.
//  3 Write addr 5=0xA5 and read addr 5 on port 0 in the same cycle -> RD_DATA[0]=0xA5
//    next cycle (bypass). Port 1 reading addr 6 gets the old value.
//  4 NUM_WR=2: WR0 addr 9=0x11 and WR1 addr 9=0x22 in one cycle -> later read of
//    addr 9 = 0x22.
//  5 Assert RST at clear cycle 10, hold 1 cycle -> clear restarts. BUSY stays high
//    32 cycles after release. Data written before reset reads 0 afterwards.
//  6 RD_EN=0 for 3 cycles after a read of 0x1234 -> RD_DATA holds 0x1234,
//    RD_VALID=0 throughout.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the multi-port register file: clear FSM encoding and
// default geometry matching the global datapath word and register-address widths.
package register_file_mp_pkg;

    localparam logic [0:0] RF_CLEAR = 1'b0;
    localparam logic [0:0] RF_READY = 1'b1;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

endpackage

// File: rtl/register_file_mp_read_port.sv
// One registered read port: address mux, hardwired-zero entry, write-first
// bypass against the same-cycle writes, and the output register.
module register_file_mp_read_port
    import register_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [DATA_WIDTH-1:0]        mem [DEPTH],
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid
);

    logic                  byp_hit_s;
    logic [DATA_WIDTH-1:0] byp_data_s;
    logic [DATA_WIDTH-1:0] next_data_s;

    // Select read source; later write ports override earlier ones, matching array priority
    always_comb begin
        byp_hit_s  = 1'b0;
        byp_data_s = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr)) begin
                byp_hit_s  = 1'b1;
                byp_data_s = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                byp_hit_s  = byp_hit_s;
                byp_data_s = byp_data_s;
            end
        end
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            next_data_s = '0;
        end else if (byp_hit_s) begin
            next_data_s = byp_data_s;
        end else begin
            next_data_s = mem[rd_addr];
        end
    end

    // Output register: data holds when no read is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= next_data_s;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with registered reads, write-first bypass,
// optional hardwired-zero entry 0 and a post-reset clear sequencer.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_RD-1:0]            RD_EN,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] RD_ADDR,
    output logic [NUM_RD*DATA_WIDTH-1:0] RD_DATA,
    output logic [NUM_RD-1:0]            RD_VALID,
    input  logic [NUM_WR-1:0]            WR_EN,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [NUM_WR*DATA_WIDTH-1:0] WR_DATA,
    output logic                         BUSY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Extra pointer bit lets the last-entry compare stay free of wrap-around
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CLR_ONE  = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [0:0]            state_r;
    logic [ADDR_WIDTH:0]   clr_ptr_r;
    logic                  busy_r;
    logic                  ready_s;
    logic [NUM_WR-1:0]     wr_ok_s;

    assign ready_s = (state_r == RF_READY);
    assign BUSY    = busy_r;

    // Qualify write ports: only in READY, and never to the hardwired-zero entry
    always_comb begin
        wr_ok_s = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if ((ZERO_REG != 0) && (WR_ADDR[w*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                wr_ok_s[w] = 1'b0;
            end else begin
                wr_ok_s[w] = ready_s & WR_EN[w];
            end
        end
    end

    // Clear sequencer and array writes; reset restarts the clear but leaves contents alone
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= RF_CLEAR;
            clr_ptr_r <= '0;
            busy_r    <= 1'b1;
        end else begin
            case (state_r)
                RF_CLEAR: begin
                    mem_r[clr_ptr_r[ADDR_WIDTH-1:0]] <= '0;
                    clr_ptr_r <= clr_ptr_r + CLR_ONE;
                    if (clr_ptr_r == CLR_LAST) begin
                        state_r <= RF_READY;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= RF_CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                RF_READY: begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (wr_ok_s[w]) begin
                            mem_r[WR_ADDR[w*ADDR_WIDTH +: ADDR_WIDTH]] <= WR_DATA[w*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                default: begin
                    state_r   <= RF_CLEAR;
                    clr_ptr_r <= '0;
                    busy_r    <= 1'b1;
                end
            endcase
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        register_file_mp_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_WR     (NUM_WR),
            .ZERO_REG   (ZERO_REG),
            .DEPTH      (DEPTH)
        ) u_rd_port (
            .clk      (CLK),
            .rst      (RST),
            .rd_en    (RD_EN[p] & ready_s),
            .rd_addr  (RD_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .mem      (mem_r),
            .wr_en    (wr_ok_s),
            .wr_addr  (WR_ADDR),
            .wr_data  (WR_DATA),
            .rd_data  (RD_DATA[p*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid (RD_VALID[p])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp (2 read ports, 2 write ports, zero reg):
// a behavioural array model pushes expected read data, checked one cycle later.
module tb_register_file_mp;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [1:0]  RD_EN = '0;
    logic [9:0]  RD_ADDR = '0;
    logic [63:0] RD_DATA;
    logic [1:0]  RD_VALID;
    logic [1:0]  WR_EN = '0;
    logic [9:0]  WR_ADDR = '0;
    logic [63:0] WR_DATA = '0;
    logic        BUSY;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] mem_m [32];
    logic [31:0] exp_q [2][$];
    logic [31:0] last_exp [2];
    bit          model_busy = 1'b1;

    register_file_mp #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_RD     (2),
        .NUM_WR     (2),
        .ZERO_REG   (1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RD_EN    (RD_EN),
        .RD_ADDR  (RD_ADDR),
        .RD_DATA  (RD_DATA),
        .RD_VALID (RD_VALID),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
    endtask

    // Advance one edge, then compare valid and data of every port against the scoreboard
    task automatic cycle();
        @(posedge CLK);
        #1;
        for (int p = 0; p < 2; p++) begin
            logic exp_v;
            if (RST) begin
                exp_q[p].delete();
                last_exp[p] = '0;
            end
            exp_v = (exp_q[p].size() != 0);
            check($sformatf("rd_valid%0d", p), {31'd0, RD_VALID[p]}, {31'd0, exp_v});
            if (exp_v) last_exp[p] = exp_q[p].pop_front();
            check($sformatf("rd_data%0d", p), RD_DATA[p*32 +: 32], last_exp[p]);
        end
    endtask

    task automatic drive(input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1);
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [4:0]  ra [2];
        wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
        RD_EN = ren; RD_ADDR = {ra1, ra0};
        WR_EN = wen; WR_ADDR = {wa1, wa0}; WR_DATA = {wd1, wd0};
        if (!model_busy) begin
            for (int w = 0; w < 2; w++)
                if (wen[w] && wa[w] != 5'd0) mem_m[wa[w]] = wd[w];
            for (int p = 0; p < 2; p++)
                if (ren[p]) exp_q[p].push_back((ra[p] == 5'd0) ? 32'd0 : mem_m[ra[p]]);
        end
        cycle();
    endtask

    // Reset, then count BUSY-high samples; reads/writes issued during the clear must be ignored
    task automatic reset_and_clear(input int rst_cycles);
        int n;
        RST = 1'b1; model_busy = 1'b1;
        RD_EN = 2'b11; RD_ADDR = {5'd3, 5'd3};
        WR_EN = 2'b11; WR_ADDR = {5'd1, 5'd1}; WR_DATA = {32'hDEAD_0001, 32'hBEEF_0001};
        for (int i = 0; i < rst_cycles; i++) begin
            cycle();
            check("busy_in_rst", {31'd0, BUSY}, 32'd1);
        end
        RST = 1'b0;
        n = 1;
        while (n < 100) begin
            cycle();
            if (BUSY) n++;
            else break;
        end
        check("busy_len", n, 32'd32);
        RD_EN = '0; WR_EN = '0;
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        model_busy = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        last_exp[0] = '0; last_exp[1] = '0;
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        @(negedge CLK);

        reset_and_clear(2);
        for (int i = 0; i < 32; i++)
            drive(2'b11, 5'(i), 5'(31 - i), 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        for (int i = 0; i < 32; i++)
            drive(2'b00, 5'd0, 5'd0, 2'b01, 5'(i), 32'(i * 10), 5'd0, 32'd0);
        for (int i = 0; i < 32; i++)
            drive(2'b11, 5'(i), 5'(i % 7), 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        drive(2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
        drive(2'b11, 5'd0, 5'd0, 2'b11, 5'd0, 32'h0000_0077, 5'd0, 32'h0000_0088);

        drive(2'b11, 5'd5, 5'd6, 2'b01, 5'd5, 32'h0000_00A5, 5'd0, 32'd0);
        drive(2'b11, 5'd5, 5'd6, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        drive(2'b11, 5'd9, 5'd8, 2'b11, 5'd9, 32'h0000_0011, 5'd9, 32'h0000_0022);
        drive(2'b11, 5'd9, 5'd9, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        drive(2'b11, 5'd10, 5'd11, 2'b11, 5'd11, 32'h0000_0B0B, 5'd10, 32'h0000_0A0A);

        drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd12, 32'h0000_1234, 5'd0, 32'd0);
        drive(2'b01, 5'd12, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++)
            drive(2'b00, 5'd12, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        for (int i = 0; i < 80; i++)
            drive(2'($urandom), 5'($urandom_range(15)), 5'($urandom_range(15)),
                  2'($urandom), 5'($urandom_range(15)), $urandom,
                  5'($urandom_range(15)), $urandom);

        drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd20, 32'h0000_2020, 5'd0, 32'd0);
        RST = 1'b1; model_busy = 1'b1; RD_EN = '0; WR_EN = '0;
        cycle();
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("busy_mid_clear", {31'd0, BUSY}, 32'd1);
        end
        reset_and_clear(1);
        drive(2'b11, 5'd5, 5'd9, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        drive(2'b11, 5'd12, 5'd20, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        drive(2'b11, 5'd1, 5'd31, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
